// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: block types, decoder states, candidate count and
// helpers for building and rotating (dx,dy) cell offsets.
package tetris_pkg;

   typedef enum logic [2:0] {
      BLK_O = 3'd0,
      BLK_I = 3'd1,
      BLK_L = 3'd2,
      BLK_J = 3'd3,
      BLK_S = 3'd4,
      BLK_Z = 3'd5,
      BLK_T = 3'd6
   } block_t;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SEARCH  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam int NUM_CANDIDATES = 112;

   typedef struct packed {
      logic signed [2:0] dx;
      logic signed [2:0] dy;
   } offset_t;

   function automatic offset_t mk_off(input int dx, input int dy);
      offset_t o;
      o.dx = 3'(dx);
      o.dy = 3'(dy);
      return o;
   endfunction

   // Quarter turns of (dx,dy) -> (-dy,dx).
   function automatic offset_t rotate_offset(input offset_t o, input logic [1:0] rot);
      offset_t r;
      case (rot)
         2'd0: r = o;
         2'd1: begin r.dx = -o.dy; r.dy =  o.dx; end
         2'd2: begin r.dx = -o.dx; r.dy = -o.dy; end
         default: begin r.dx = o.dy; r.dy = -o.dx; end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shape_offsets.sv
// Combinational tetromino geometry: four (dx,dy) offsets for a (type, rot) pair,
// entry 0 is always the pivot. Single source of shape data for forward and inverse mappers.
module shape_offsets
   import tetris_pkg::*;
(
   input  logic [2:0]    blk,
   input  logic [1:0]    rot,
   output offset_t [3:0] offsets
);

   offset_t [3:0] base;
   logic [1:0]    eff_rot;

   always_comb begin
      base    = '0;
      eff_rot = rot;
      base[0] = mk_off(0, 0);
      case (blk)
         BLK_I: begin
            base[1] = mk_off(-1, 0); base[2] = mk_off(1, 0); base[3] = mk_off(2, 0);
            // Horizontal/vertical only; keeps every offset inside -1..+2.
            eff_rot = {1'b0, rot[0]};
         end
         BLK_L: begin
            base[1] = mk_off(-1, 0); base[2] = mk_off(1, 0); base[3] = mk_off(1, 1);
         end
         BLK_J: begin
            base[1] = mk_off(-1, 0); base[2] = mk_off(1, 0); base[3] = mk_off(-1, 1);
         end
         BLK_S: begin
            base[1] = mk_off(-1, 0); base[2] = mk_off(0, 1); base[3] = mk_off(1, 1);
         end
         BLK_Z: begin
            base[1] = mk_off(1, 0); base[2] = mk_off(0, 1); base[3] = mk_off(-1, 1);
         end
         BLK_T: begin
            base[1] = mk_off(-1, 0); base[2] = mk_off(1, 0); base[3] = mk_off(0, 1);
         end
         default: begin
            base[1] = mk_off(1, 0); base[2] = mk_off(0, 1); base[3] = mk_off(1, 1);
            eff_rot = 2'd0;
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         offsets[i] = rotate_offset(base[i], eff_rot);
      end
   end

endmodule

// File: rtl/piece_decoder.sv
// Inverse piece mapper: collects four cells, scans all (type, rot, pivot) candidates.
// PIECE_DECODER_EARLY_EXIT_EN: stop the scan at the first match instead of fixed latency.
//
// state   | meaning
// COLLECT | accepting cell beats 0..3
// SEARCH  | evaluating candidate k = type*16 + rot*4 + p, one per cycle
// RESPOND | result presented, waiting for out_ready
module piece_decoder
   import tetris_pkg::*;
#(
   parameter int X_W = 4,
   parameter int Y_W = 5
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [X_W-1:0] in_x,
   input  logic [Y_W-1:0] in_y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2:0]     out_type,
   output logic [2:0]     out_rot,
   output logic [X_W-1:0] out_x,
   output logic [Y_W-1:0] out_y,
   output logic           out_err
);

   state_t         state, state_nx;
   logic [X_W-1:0] cell_x [4];
   logic [Y_W-1:0] cell_y [4];
   logic [1:0]     beat;
   logic [6:0]     k;
   logic           found;
   offset_t [3:0]  offsets;
   logic [X_W+1:0] ex [4];
   logic [Y_W+1:0] ey [4];
   logic [3:0]     hit;
   logic           match;
   logic           last_cand;
   logic           done;
   logic           beat_xfer;

   shape_offsets u_shape (
      .blk     (k[6:4]),
      .rot     (k[3:2]),
      .offsets (offsets)
   );

   assign in_ready  = resetn && (state == COLLECT);
   assign out_valid = (state == RESPOND);
   assign beat_xfer = in_valid && in_ready;
   assign last_cand = (k == 7'(NUM_CANDIDATES - 1));

`ifdef PIECE_DECODER_EARLY_EXIT_EN
   assign done = last_cand || match;
`else
   assign done = last_cand;
`endif

   // Two extra bits catch both underflow below 0 and overflow past 2^W-1.
   always_comb begin
      match = 1'b1;
      hit   = '0;
      for (int i = 0; i < 4; i++) begin
         ex[i] = {2'b00, cell_x[k[1:0]]} + {{(X_W-1){offsets[i].dx[2]}}, offsets[i].dx};
         ey[i] = {2'b00, cell_y[k[1:0]]} + {{(Y_W-1){offsets[i].dy[2]}}, offsets[i].dy};
         for (int j = 0; j < 4; j++) begin
            if (ex[i][X_W+1:X_W] == 2'b00 && ey[i][Y_W+1:Y_W] == 2'b00 &&
                ex[i][X_W-1:0] == cell_x[j] && ey[i][Y_W-1:0] == cell_y[j]) begin
               hit[i] = 1'b1;
            end
         end
         match = match & hit[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) state <= COLLECT;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         COLLECT: if (beat_xfer && beat == 2'd3) state_nx = SEARCH;
         SEARCH:  if (done) state_nx = RESPOND;
         RESPOND: if (out_ready) state_nx = COLLECT;
         default: state_nx = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         beat     <= '0;
         k        <= '0;
         found    <= 1'b0;
         out_type <= '0;
         out_rot  <= '0;
         out_x    <= '0;
         out_y    <= '0;
         out_err  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cell_x[i] <= '0;
            cell_y[i] <= '0;
         end
      end else begin
         case (state)
            COLLECT: begin
               if (beat_xfer) begin
                  cell_x[beat] <= in_x;
                  cell_y[beat] <= in_y;
                  beat         <= beat + 2'd1;
                  if (beat == 2'd3) begin
                     k        <= '0;
                     found    <= 1'b0;
                     out_type <= '0;
                     out_rot  <= '0;
                     out_x    <= '0;
                     out_y    <= '0;
                     out_err  <= 1'b0;
                  end
               end
            end
            SEARCH: begin
               k <= k + 7'd1;
               // Only the first match is kept, so the lowest equivalent rot wins.
               if (match && !found) begin
                  found    <= 1'b1;
                  out_type <= k[6:4];
                  out_rot  <= {1'b0, k[3:2]};
                  out_x    <= cell_x[k[1:0]];
                  out_y    <= cell_y[k[1:0]];
               end
               if (last_cand && !found && !match) out_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_piece_decoder.sv
// Scoreboard bench for piece_decoder: directed cell sets, expected results queued by the
// driver and checked by a monitor on out_valid rise and at the output handshake.
module tb_piece_decoder;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_x = '0;
   logic [4:0] in_y = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [2:0] out_type;
   logic [2:0] out_rot;
   logic [3:0] out_x;
   logic [4:0] out_y;
   logic       out_err;

   piece_decoder #(.X_W(4), .Y_W(5)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_type  (out_type),
      .out_rot   (out_rot),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t; int r; int x; int y; int e; int k; int lat; int n4;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   bx[4];
   int   by[4];
   logic prev_v = 1'b0;
   int   cap_t, cap_r, cap_x, cap_y, cap_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic finish_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask

   // Monitor: samples just after the falling edge, after the driver has settled.
   always @(negedge clk) begin
      #1;
      if (!resetn) begin
         prev_v = 1'b0;
      end else begin
         if (out_valid && !prev_v) begin
            if (sb.size() == 0) begin
               chk("unexpected_response", 1, 0);
            end else begin
               cur = sb.pop_front();
               chk("type", int'(out_type), cur.t);
               chk("rot", int'(out_rot), cur.r);
               chk("x", int'(out_x), cur.x);
               chk("y", int'(out_y), cur.y);
               chk("err", int'(out_err), cur.e);
               chk($sformatf("latency_k%0d", cur.k), cyc - cur.n4, cur.lat);
            end
            cap_t = int'(out_type);
            cap_r = int'(out_rot);
            cap_x = int'(out_x);
            cap_y = int'(out_y);
            cap_e = int'(out_err);
         end
         if (out_valid && out_ready) begin
            chk("hold_type", int'(out_type), cap_t);
            chk("hold_rot", int'(out_rot), cap_r);
            chk("hold_x", int'(out_x), cap_x);
            chk("hold_y", int'(out_y), cap_y);
            chk("hold_err", int'(out_err), cap_e);
            chk("in_ready_in_respond", int'(in_ready), 0);
         end
         prev_v = out_valid;
      end
   end

   task automatic set_cells(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input int x3, input int y3);
      bx[0] = x0; by[0] = y0; bx[1] = x1; by[1] = y1;
      bx[2] = x2; by[2] = y2; bx[3] = x3; by[3] = y3;
   endtask

   // Called at a falling edge; returns at a falling edge after the 4th transfer.
   task automatic send(input bit push, input int t, input int r, input int x, input int y,
                       input int e, input int k);
      exp_t ex;
      int   n;
      for (int b = 0; b < 4; b++) begin
         in_valid = 1'b1;
         in_x     = 4'(bx[b]);
         in_y     = 5'(by[b]);
         n = 0;
         while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
               chk("beat_accept_timeout", 0, 1);
               finish_run();
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (push) begin
         ex.t = t; ex.r = r; ex.x = x; ex.y = y; ex.e = e; ex.k = k;
`ifdef PIECE_DECODER_EARLY_EXIT_EN
         ex.lat = (e != 0) ? 112 : 1 + k;
`else
         ex.lat = 112;
`endif
         ex.n4 = cyc;
         sb.push_back(ex);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("drain_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      chk("global_timeout", 0, 1);
      finish_run();
   end

   initial begin
      int n;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_err", int'(out_err), 0);
      chk("rst_out_type", int'(out_type), 0);
      chk("rst_out_rot", int'(out_rot), 0);
      chk("rst_out_x", int'(out_x), 0);
      chk("rst_out_y", int'(out_y), 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 1);

      // T rot0 pivot (5,10): k = 6*16 + 0 + 0
      set_cells(5, 10, 5, 11, 4, 10, 6, 10);
      send(1, 6, 0, 5, 10, 0, 96);
      wait_idle();
      // O scrambled, pivot is beat 1: k = 1
      set_cells(3, 1, 2, 0, 3, 0, 2, 1);
      send(1, 0, 0, 2, 0, 0, 1);
      wait_idle();
      // Column 15 next to column 0 must not wrap into an I
      set_cells(15, 7, 0, 7, 1, 7, 2, 7);
      send(1, 0, 0, 0, 0, 1, 0);
      wait_idle();
      // I rot0 pivot (1,7) is beat 1: k = 16 + 0 + 1
      set_cells(0, 7, 1, 7, 2, 7, 3, 7);
      send(1, 1, 0, 1, 7, 0, 17);
      wait_idle();
      set_cells(0, 0, 2, 0, 4, 0, 6, 0);
      send(1, 0, 0, 0, 0, 1, 0);
      wait_idle();
      set_cells(5, 5, 5, 5, 5, 5, 5, 5);
      send(1, 0, 0, 0, 0, 1, 0);
      wait_idle();
      // J rot3 pivot (14,20), beat 2: k = 3*16 + 3*4 + 2
      set_cells(15, 21, 14, 19, 14, 20, 14, 21);
      send(1, 3, 3, 14, 20, 0, 62);
      wait_idle();

      // Z rot0 pivot (5,5), beat 3: k = 5*16 + 0 + 3; consumer stalls 5+ cycles
      out_ready = 1'b0;
      set_cells(4, 6, 5, 6, 6, 5, 5, 5);
      send(1, 5, 0, 5, 5, 0, 83);
      n = 0;
      while (!out_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("stall_response_seen", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_out_valid", int'(out_valid), 1);
         chk("stall_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_in_ready", int'(in_ready), 1);
      chk("post_hs_out_valid", int'(out_valid), 0);
      wait_idle();

      // Abort a search with reset, then decode a fresh L rot1 at (4,4): k = 2*16 + 4 + 0
      set_cells(5, 10, 5, 11, 4, 10, 6, 10);
      send(0, 0, 0, 0, 0, 0, 0);
      repeat (20) @(negedge clk);
      chk("mid_search_out_valid", int'(out_valid), 0);
      chk("mid_search_in_ready", int'(in_ready), 0);
      resetn = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_in_ready", int'(in_ready), 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("abort_idle_in_ready", int'(in_ready), 1);
      set_cells(4, 4, 4, 5, 3, 5, 4, 3);
      send(1, 2, 1, 4, 4, 0, 36);
      wait_idle();

      finish_run();
   end

endmodule
